// File: rtl/aes_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_dma_pkg
//  Description : Shared definitions for the AES DMA stage: FSM state
//                encoding, default coprocessor addresses, the MMIO_AES
//                control-bit layout and small address/control helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_dma_pkg;

    // Transfer sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LD_RD  = 3'd1,
        ST_LD_WR  = 3'd2,
        ST_KICK   = 3'd3,
        ST_POLL   = 3'd4,
        ST_DR_RD  = 3'd5,
        ST_DR_WR  = 3'd6,
        ST_FINISH = 3'd7
    } aes_dma_state_e;

    // Default coprocessor memory map
    localparam logic [31:0] C_AES_BUF_BASE_DEF  = 32'h0004_0000;
    localparam logic [31:0] C_AES_CTRL_ADDR_DEF = 32'h0004_0300;

    // MMIO_AES control-register bit positions
    localparam int C_CTRL_ENC_BIT   = 0;
    localparam int C_CTRL_DEC_BIT   = 1;
    localparam int C_CTRL_VALID_BIT = 2;

    // Byte address of word idx in a region; base low bits are ignored
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [7:0]  idx);
        return (base & 32'hFFFF_FFFC) + {22'd0, idx, 2'b00};
    endfunction

    // Control word that starts an encrypt (dec=0) or decrypt (dec=1)
    function automatic logic [31:0] ctrl_word(input logic dec);
        logic [31:0] w;
        w                 = '0;
        w[C_CTRL_ENC_BIT] = ~dec;
        w[C_CTRL_DEC_BIT] = dec;
        return w;
    endfunction

endpackage : aes_dma_pkg
`default_nettype wire

// File: rtl/aes_dma.sv
`default_nettype none
// ============================================================================
//  Module      : aes_dma
//  Description : Bus-master DMA in front of the AES coprocessor. Loads N
//                words from main memory into the coprocessor buffer, kicks
//                an encrypt/decrypt through MMIO_AES, polls for the
//                valid-result bit and drains N result words back to memory.
//                Optional macro AES_DMA_TIMEOUT_EN adds a poll timeout that
//                clears the control register, flags err_out and skips the
//                drain.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_dma
    import aes_dma_pkg::*;
#(
    parameter int          BUF_WORDS     = 192,
    parameter logic [31:0] AES_BUF_BASE  = C_AES_BUF_BASE_DEF,
    parameter logic [31:0] AES_CTRL_ADDR = C_AES_CTRL_ADDR_DEF
`ifdef AES_DMA_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        decrypt_in,
    input  logic [31:0] src_base_in,
    input  logic [31:0] dst_base_in,
    input  logic [7:0]  len_words_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        err_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_data_out,
    output logic [3:0]  mem_we_out,
    input  logic [31:0] mem_data_in,
    output logic [31:0] aes_addr_out,
    output logic [31:0] aes_data_out,
    output logic [3:0]  aes_we_out,
    input  logic [31:0] aes_data_in
);

`ifdef AES_DMA_TIMEOUT_EN
    localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
`endif

    aes_dma_state_e r_state;
    logic           r_dec;
    logic [31:0]    r_src;
    logic [31:0]    r_dst;
    logic [7:0]     r_len;
    logic [7:0]     r_idx;
    logic           r_poll_first;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic [31:0]    r_mem_addr;
    logic [3:0]     r_mem_we;
    logic [31:0]    r_aes_addr;
    logic [3:0]     r_aes_we;
    logic [31:0]    r_aes_data;
`ifdef AES_DMA_TIMEOUT_EN
    logic [15:0]    r_cnt;
    logic           r_abort;
`endif

    logic           w_last;
    logic           w_len_too_big;
    logic [7:0]     w_idx_next;

    assign w_idx_next    = r_idx + 8'd1;
    assign w_last        = (r_idx == (r_len - 8'd1));
    assign w_len_too_big = ({24'd0, len_words_in} > 32'(BUF_WORDS));

    // Sequencer: every bus output is registered for the state being entered
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= ST_IDLE;
            r_dec        <= 1'b0;
            r_src        <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_poll_first <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= '0;
            r_aes_addr   <= '0;
            r_aes_we     <= '0;
            r_aes_data   <= '0;
`ifdef AES_DMA_TIMEOUT_EN
            r_cnt        <= '0;
            r_abort      <= 1'b0;
`endif
        end else begin
            // Bus strobes default to quiet; each state re-asserts its own
            r_done     <= 1'b0;
            r_mem_addr <= '0;
            r_mem_we   <= '0;
            r_aes_addr <= '0;
            r_aes_we   <= '0;
            r_aes_data <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (start_in) begin
                        r_dec  <= decrypt_in;
                        r_src  <= src_base_in;
                        r_dst  <= dst_base_in;
                        r_len  <= len_words_in;
                        r_idx  <= '0;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (len_words_in == 8'd0) begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end else if (w_len_too_big) begin
                            r_err   <= 1'b1;
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ST_LD_RD;
                            r_mem_addr <= word_addr(src_base_in, 8'd0);
                        end
                    end
                end
                ST_LD_RD: begin
                    // Read data arrives next cycle and is forwarded to the buffer
                    r_state    <= ST_LD_WR;
                    r_aes_addr <= word_addr(AES_BUF_BASE, r_idx);
                    r_aes_we   <= 4'hF;
                end
                ST_LD_WR: begin
                    r_idx <= w_idx_next;
                    if (w_last) begin
                        r_state    <= ST_KICK;
                        r_aes_addr <= AES_CTRL_ADDR;
                        r_aes_we   <= 4'h1;
                        r_aes_data <= ctrl_word(r_dec);
                    end else begin
                        r_state    <= ST_LD_RD;
                        r_mem_addr <= word_addr(r_src, w_idx_next);
                    end
                end
                ST_KICK: begin
`ifdef AES_DMA_TIMEOUT_EN
                    if (r_abort) begin
                        r_abort <= 1'b0;
                        r_state <= ST_FINISH;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= ST_POLL;
                        r_idx        <= '0;
                        r_poll_first <= 1'b1;
                        r_aes_addr   <= AES_CTRL_ADDR;
                        r_cnt        <= '0;
                    end
`else
                    r_state      <= ST_POLL;
                    r_idx        <= '0;
                    r_poll_first <= 1'b1;
                    r_aes_addr   <= AES_CTRL_ADDR;
`endif
                end
                ST_POLL: begin
                    // First poll cycle returns the read issued during KICK,
                    // which may still show the previous job's valid bit
                    r_poll_first <= 1'b0;
                    if (!r_poll_first && aes_data_in[C_CTRL_VALID_BIT]) begin
                        r_state    <= ST_DR_RD;
                        r_aes_addr <= word_addr(AES_BUF_BASE, r_idx);
                    end
`ifdef AES_DMA_TIMEOUT_EN
                    else if (r_cnt == C_TIMEOUT_LAST) begin
                        r_err      <= 1'b1;
                        r_abort    <= 1'b1;
                        r_state    <= ST_KICK;
                        r_aes_addr <= AES_CTRL_ADDR;
                        r_aes_we   <= 4'h1;
                        r_aes_data <= '0;
                    end else begin
                        r_cnt      <= r_cnt + 16'd1;
                        r_aes_addr <= AES_CTRL_ADDR;
                    end
`else
                    else begin
                        r_aes_addr <= AES_CTRL_ADDR;
                    end
`endif
                end
                ST_DR_RD: begin
                    r_state    <= ST_DR_WR;
                    r_mem_addr <= word_addr(r_dst, r_idx);
                    r_mem_we   <= 4'hF;
                end
                ST_DR_WR: begin
                    r_idx <= w_idx_next;
                    if (w_last) begin
                        r_state <= ST_FINISH;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= ST_DR_RD;
                        r_aes_addr <= word_addr(AES_BUF_BASE, w_idx_next);
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_out     = r_busy;
    assign done_out     = r_done;
    assign err_out      = r_err;
    assign mem_addr_out = r_mem_addr;
    assign mem_we_out   = r_mem_we;
    assign aes_addr_out = r_aes_addr;
    assign aes_we_out   = r_aes_we;
    // Read data is only valid the cycle after the address, so the write
    // cycles forward the opposite bus's read data straight through
    assign aes_data_out = (r_state == ST_LD_WR) ? mem_data_in : r_aes_data;
    assign mem_data_out = (r_state == ST_DR_WR) ? aes_data_in : 32'd0;

endmodule : aes_dma
`default_nettype wire

// File: tb/tb_aes_dma.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_dma
//  Description : Self-checking bench for aes_dma with a synchronous-read
//                main memory, a coprocessor model that inverts the buffer
//                and raises the valid bit a set delay after a start command,
//                a table of directed transfers, multi-cycle corner sequences
//                and randomized transfers against a list-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_dma;

    localparam logic [31:0] BUF_BASE = 32'h0004_0000;
    localparam logic [31:0] CTRL     = 32'h0004_0300;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        start_in;
    logic        decrypt_in;
    logic [31:0] src_base_in;
    logic [31:0] dst_base_in;
    logic [7:0]  len_words_in;
    logic        busy_out;
    logic        done_out;
    logic        err_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_data_out;
    logic [3:0]  mem_we_out;
    logic [31:0] mem_data_in;
    logic [31:0] aes_addr_out;
    logic [31:0] aes_data_out;
    logic [3:0]  aes_we_out;
    logic [31:0] aes_data_in;

    always #5 clk_in = ~clk_in;

`ifdef AES_DMA_TIMEOUT_EN
    aes_dma #(.TIMEOUT_CYCLES(16)) dut (
`else
    aes_dma dut (
`endif
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
        .decrypt_in(decrypt_in), .src_base_in(src_base_in),
        .dst_base_in(dst_base_in), .len_words_in(len_words_in),
        .busy_out(busy_out), .done_out(done_out), .err_out(err_out),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
        .mem_we_out(mem_we_out), .mem_data_in(mem_data_in),
        .aes_addr_out(aes_addr_out), .aes_data_out(aes_data_out),
        .aes_we_out(aes_we_out), .aes_data_in(aes_data_in)
    );

    // ---------------- main memory: read-only source, 1-cycle read ----------
    logic [31:0] mem [0:8191];
    always @(posedge clk_in) mem_data_in <= mem[mem_addr_out[14:2]];

    // ---------------- coprocessor model -------------------------------------
    logic [31:0] cop_buf [0:255];
    logic [31:0] ctrl_reg = 32'd0;
    int          cd = 0;
    int          valid_lat;
    bit          never_valid;
    logic [31:0] cop_off;
    logic        cop_in_buf;
    assign cop_off    = (aes_addr_out - BUF_BASE) >> 2;
    assign cop_in_buf = (aes_addr_out >= BUF_BASE) && (aes_addr_out < BUF_BASE + 32'd768);

    always @(posedge clk_in) begin
        if (aes_addr_out == CTRL)  aes_data_in <= ctrl_reg;
        else if (cop_in_buf)       aes_data_in <= ~cop_buf[cop_off[7:0]];
        else                       aes_data_in <= 32'd0;
        if (aes_we_out != 4'd0 && aes_addr_out == CTRL) begin
            ctrl_reg <= {24'd0, aes_data_out[7:0]};
            cd       <= ((aes_data_out[1:0] != 2'b00) && !never_valid) ? valid_lat : 0;
        end else begin
            if (aes_we_out != 4'd0 && cop_in_buf) cop_buf[cop_off[7:0]] <= aes_data_out;
            if (cd > 0) begin
                cd <= cd - 1;
                if (cd == 1) ctrl_reg[2] <= 1'b1;
            end
        end
    end

    // ---------------- bus monitor -------------------------------------------
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t         buf_log[$];
    wr_t         dst_log[$];
    logic [31:0] ctrl_log[$];
    int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;
    int mem_act = 0, aes_act = 0, poll_cnt = 0;
    int dbl_done = 0, busy_after = 0, multi_we = 0;
    logic prev_done = 1'b0;

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (start_in && !busy_out) start_cyc <= cyc;
        if (done_out) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (prev_done && done_out) dbl_done <= dbl_done + 1;
        if (prev_done && busy_out) busy_after <= busy_after + 1;
        prev_done <= done_out;
        if (mem_we_out != 4'd0 && aes_we_out != 4'd0) multi_we <= multi_we + 1;
        if (mem_addr_out != 32'd0 || mem_we_out != 4'd0) mem_act <= mem_act + 1;
        if (aes_addr_out != 32'd0 || aes_we_out != 4'd0) aes_act <= aes_act + 1;
        if (busy_out && aes_addr_out == CTRL && aes_we_out == 4'd0) poll_cnt <= poll_cnt + 1;
        if (mem_we_out != 4'd0) dst_log.push_back('{mem_addr_out, mem_data_out});
        if (aes_we_out != 4'd0) begin
            if (aes_addr_out == CTRL) ctrl_log.push_back(aes_data_out);
            else                      buf_log.push_back('{aes_addr_out, aes_data_out});
        end
    end

    // ---------------- checking helpers --------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    int b_buf, b_dst, b_ctrl, b_done, b_mem, b_aes, b_poll;

    task automatic launch(input logic [31:0] src, input logic [31:0] dst,
                          input logic [7:0] len, input logic dec, input bit pat);
        if (len <= 8'd192)
            for (int i = 0; i < int'(len); i++)
                mem[13'(int'(src[14:2]) + i)] = pat ? (32'hA0 + 32'(i)) : $urandom;
        @(negedge clk_in);
        b_buf  = buf_log.size();  b_dst = dst_log.size(); b_ctrl = ctrl_log.size();
        b_done = done_cnt;        b_mem = mem_act;        b_aes  = aes_act;
        b_poll = poll_cnt;
        src_base_in  = src;
        dst_base_in  = dst;
        len_words_in = len;
        decrypt_in   = dec;
        start_in     = 1'b1;
        @(negedge clk_in);
        start_in     = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == b_done && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        check("done_seen", 32'(done_cnt != b_done), 32'd1);
        repeat (2) @(negedge clk_in);
    endtask

    // Model: len words copied in order, one control write, inverted results out
    task automatic verify(input logic [31:0] src, input logic [31:0] dst,
                          input logic [7:0] len, input logic dec, input logic exp_err);
        int          n_exp;
        logic [31:0] sw;
        n_exp = (len == 8'd0 || len > 8'd192) ? 0 : int'(len);
        sw    = {17'd0, src[14:2], 2'b00};
        check("done_pulses", 32'(done_cnt - b_done), 32'd1);
        check("err_out", {31'd0, err_out}, {31'd0, exp_err});
        check("busy_after_done", {31'd0, busy_out}, 32'd0);
        check("buf_write_count", 32'(buf_log.size() - b_buf), 32'(n_exp));
        check("dst_write_count", 32'(dst_log.size() - b_dst), 32'(n_exp));
        if (n_exp == 0) begin
            check("mem_accesses", 32'(mem_act - b_mem), 32'd0);
            check("aes_accesses", 32'(aes_act - b_aes), 32'd0);
            check("done_latency", 32'(done_cyc - start_cyc), 32'd1);
        end else begin
            check("ctrl_write_count", 32'(ctrl_log.size() - b_ctrl), 32'd1);
            if (ctrl_log.size() > b_ctrl)
                check("ctrl_value", ctrl_log[b_ctrl], dec ? 32'd2 : 32'd1);
            if (buf_log.size() - b_buf == n_exp && dst_log.size() - b_dst == n_exp)
                for (int i = 0; i < n_exp; i++) begin
                    check("buf_addr", buf_log[b_buf + i].addr, BUF_BASE + 32'(4 * i));
                    check("buf_data", buf_log[b_buf + i].data, mem[13'((sw >> 2) + 32'(i))]);
                    check("dst_addr", dst_log[b_dst + i].addr, (dst & 32'hFFFF_FFFC) + 32'(4 * i));
                    check("dst_data", dst_log[b_dst + i].data, ~mem[13'((sw >> 2) + 32'(i))]);
                end
        end
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [7:0]  len;
        logic        dec;
        logic        exp_err;
        bit          pat;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] rs, rd;
        logic [7:0]  rl;
        rst_n_in = 1'b0; start_in = 1'b0; decrypt_in = 1'b0;
        src_base_in = '0; dst_base_in = '0; len_words_in = '0;
        valid_lat = 10; never_valid = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
        vecs[0] = '{32'h0000_1000, 32'h0000_2000, 8'd4,   1'b0, 1'b0, 1'b1};
        vecs[1] = '{32'h0000_1100, 32'h0000_2100, 8'd1,   1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_1200, 32'h0000_2200, 8'd0,   1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_1300, 32'h0000_2300, 8'd193, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_1402, 32'h0000_2403, 8'd192, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_1800, 32'h0000_3000, 8'd255, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk_in);
        check("reset_status", {29'd0, busy_out, done_out, err_out}, 32'd0);
        check("reset_mem_bus", mem_addr_out | mem_data_out | {28'd0, mem_we_out}, 32'd0);
        check("reset_aes_bus", aes_addr_out | aes_data_out | {28'd0, aes_we_out}, 32'd0);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // Directed table
        for (int v = 0; v < 6; v++) begin
            launch(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].dec, vecs[v].pat);
            wait_done();
            verify(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].dec, vecs[v].exp_err);
        end

        // Asynchronous reset during the drain write of word 2 of 4
        launch(32'h0000_3000, 32'h0001_2000, 8'd4, 1'b0, 1'b0);
        n = 0;
        while (!(mem_we_out != 4'd0 && mem_addr_out == 32'h0001_2004) && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        check("reached_drain_word2", 32'(mem_we_out != 4'd0 && mem_addr_out == 32'h0001_2004), 32'd1);
        #2 rst_n_in = 1'b0;
        #1;
        check("abort_status", {29'd0, busy_out, done_out, err_out}, 32'd0);
        check("abort_mem_bus", mem_addr_out | mem_data_out | {28'd0, mem_we_out}, 32'd0);
        check("abort_aes_bus", aes_addr_out | aes_data_out | {28'd0, aes_we_out}, 32'd0);
        n = done_cnt;
        repeat (4) @(negedge clk_in);
        check("no_done_on_abort", 32'(done_cnt - n), 32'd0);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);
        launch(32'h0000_3100, 32'h0001_3000, 8'd4, 1'b1, 1'b0);
        wait_done();
        verify(32'h0000_3100, 32'h0001_3000, 8'd4, 1'b1, 1'b0);

        // Start pulse during POLL must be ignored
        launch(32'h0000_5000, 32'h0001_4000, 8'd3, 1'b0, 1'b0);
        n = 0;
        while (!(busy_out && aes_addr_out == CTRL && aes_we_out == 4'd0) && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        check("reached_poll", 32'(busy_out && aes_addr_out == CTRL && aes_we_out == 4'd0), 32'd1);
        src_base_in = 32'h0000_5800; dst_base_in = 32'h0001_5000;
        len_words_in = 8'd5; decrypt_in = 1'b1; start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        wait_done();
        verify(32'h0000_5000, 32'h0001_4000, 8'd3, 1'b0, 1'b0);

`ifdef AES_DMA_TIMEOUT_EN
        // Valid never rises: abort after 16 poll cycles, no drain
        never_valid = 1'b1;
        launch(32'h0000_6000, 32'h0001_6000, 8'd2, 1'b0, 1'b0);
        wait_done();
        check("to_done_pulses", 32'(done_cnt - b_done), 32'd1);
        check("to_err", {31'd0, err_out}, 32'd1);
        check("to_poll_cycles", 32'(poll_cnt - b_poll), 32'd16);
        check("to_ctrl_count", 32'(ctrl_log.size() - b_ctrl), 32'd2);
        if (ctrl_log.size() - b_ctrl == 2) begin
            check("to_ctrl_kick", ctrl_log[b_ctrl], 32'd1);
            check("to_ctrl_clear", ctrl_log[b_ctrl + 1], 32'd0);
        end
        check("to_dst_writes", 32'(dst_log.size() - b_dst), 32'd0);
        never_valid = 1'b0;
`endif

        // Randomized transfers
        for (int r = 0; r < 12; r++) begin
            rl = (r % 4 == 3) ? 8'($urandom_range(193, 255)) : 8'($urandom_range(0, 40));
            rs = 32'h1000 + 32'($urandom_range(0, 32'h5000));
            rd = 32'h0001_0000 + 32'($urandom_range(0, 32'hF000));
            valid_lat = $urandom_range(1, 10);
            launch(rs, rd, rl, 1'($urandom_range(0, 1)), 1'b0);
            wait_done();
            verify(rs, rd, rl, decrypt_in, 1'(rl > 8'd192));
        end

        check("double_done", 32'(dbl_done), 32'd0);
        check("busy_after_done_global", 32'(busy_after), 32'd0);
        check("simultaneous_we", 32'(multi_we), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_aes_dma
`default_nettype wire
